// File: rtl/btle_rx_pdu_buffer.sv
// Receive PDU buffer: captures rx octets into a circular byte memory, commits or
// rolls back each packet on decode_end, and streams committed packets out on valid/ready.
module btle_rx_pdu_buffer #(
  parameter int ADDR_WIDTH  = 9,
  parameter int LEN_FIFO_AW = 2,
  parameter int CNT_WIDTH   = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [7:0]            octet,
  input  logic                  octet_valid,
  input  logic                  decode_end,
  input  logic                  crc_ok,
  output logic [7:0]            m_data,
  output logic                  m_valid,
  output logic                  m_last,
  input  logic                  m_ready,
  output logic [ADDR_WIDTH-1:0] pkt_pending,
  output logic [CNT_WIDTH-1:0]  cnt_ok,
  output logic [CNT_WIDTH-1:0]  cnt_crc_err,
  output logic [CNT_WIDTH-1:0]  cnt_ovf
);
  localparam int DEPTH    = 1 << ADDR_WIDTH;
  localparam int LF_DEPTH = 1 << LEN_FIFO_AW;

  typedef logic [ADDR_WIDTH:0] ptr_t;
  typedef enum logic [1:0] {IDLE, RECV, DISCARD} wstate_t;

  logic [7:0] mem      [DEPTH];
  logic [7:0] len_fifo [LF_DEPTH];

  ptr_t                  wr_ptr, wr_base, rd_ptr, wr_ptr_n, wr_base_n;
  logic [ADDR_WIDTH-1:0] fetch_ptr;
  wstate_t               state, state_n, st_oct;
  logic [7:0]            len_cnt, len_n, rem;
  logic [LEN_FIFO_AW:0]  lf_wp, lf_rp;
  logic                  full, commit_room, we, push, inc_ok, inc_crc, inc_ovf;
  logic                  lf_empty, pop, fetch, hs, last_hs;

  function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] c, input logic en);
    return (en && c != '1) ? c + CNT_WIDTH'(1) : c;
  endfunction

  assign full        = (wr_ptr - rd_ptr) == ptr_t'(DEPTH);
  // a slot is held until the packet's last byte is accepted, so the streaming packet counts
  assign commit_room = pkt_pending < ADDR_WIDTH'(LF_DEPTH);

  // octet phase first, then the end-of-packet decision sees the post-octet state
  always_comb begin
    st_oct    = state;
    state_n   = state;
    wr_ptr_n  = wr_ptr;
    wr_base_n = wr_base;
    len_n     = len_cnt;
    we        = 1'b0;
    push      = 1'b0;
    inc_ok    = 1'b0;
    inc_crc   = 1'b0;
    inc_ovf   = 1'b0;
    if (octet_valid) begin
      case (state)
        IDLE, RECV: begin
          if (full) st_oct = DISCARD;
          else begin
            we       = 1'b1;
            wr_ptr_n = wr_ptr + ptr_t'(1);
            len_n    = (state == IDLE) ? 8'd1 : len_cnt + 8'd1;
            st_oct   = (len_n == 8'hFF) ? DISCARD : RECV;
          end
        end
        default: ;
      endcase
    end
    state_n = st_oct;
    if (decode_end && st_oct != IDLE) begin
      state_n = IDLE;
      if (st_oct == RECV && crc_ok && commit_room) begin
        push      = 1'b1;
        wr_base_n = wr_ptr_n;
        inc_ok    = 1'b1;
      end else begin
        wr_ptr_n = wr_base;
        if (st_oct == RECV && !crc_ok) inc_crc = 1'b1;
        else                           inc_ovf = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      wr_ptr      <= '0;
      wr_base     <= '0;
      len_cnt     <= '0;
      lf_wp       <= '0;
      cnt_ok      <= '0;
      cnt_crc_err <= '0;
      cnt_ovf     <= '0;
    end else begin
      state       <= state_n;
      wr_ptr      <= wr_ptr_n;
      wr_base     <= wr_base_n;
      len_cnt     <= len_n;
      if (push) lf_wp <= lf_wp + 1'b1;
      cnt_ok      <= sat_inc(cnt_ok, inc_ok);
      cnt_crc_err <= sat_inc(cnt_crc_err, inc_crc);
      cnt_ovf     <= sat_inc(cnt_ovf, inc_ovf);
    end
  end

  always_ff @(posedge clk) begin
    if (we)   mem[wr_ptr[ADDR_WIDTH-1:0]] <= octet;
    if (push) len_fifo[lf_wp[LEN_FIFO_AW-1:0]] <= len_n;
  end

  // read side: m_data is the enabled synchronous read port, so a byte is fetched
  // whenever the output register is empty or being consumed
  assign lf_empty = lf_wp == lf_rp;
  assign pop      = !lf_empty && rem == 8'd0;
  assign fetch    = rem != 8'd0 && (!m_valid || m_ready);
  assign hs       = m_valid && m_ready;
  assign last_hs  = hs && m_last;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rem         <= '0;
      lf_rp       <= '0;
      fetch_ptr   <= '0;
      rd_ptr      <= '0;
      m_data      <= '0;
      m_valid     <= 1'b0;
      m_last      <= 1'b0;
      pkt_pending <= '0;
    end else begin
      if (pop) begin
        rem   <= len_fifo[lf_rp[LEN_FIFO_AW-1:0]];
        lf_rp <= lf_rp + 1'b1;
      end else if (fetch) begin
        rem <= rem - 8'd1;
      end
      if (fetch) begin
        m_data    <= mem[fetch_ptr];
        m_valid   <= 1'b1;
        m_last    <= rem == 8'd1;
        fetch_ptr <= fetch_ptr + ADDR_WIDTH'(1);
      end else if (hs) begin
        m_valid <= 1'b0;
        m_last  <= 1'b0;
      end
      if (hs) rd_ptr <= rd_ptr + ptr_t'(1);
      case ({push, last_hs})
        2'b10:   pkt_pending <= pkt_pending + ADDR_WIDTH'(1);
        2'b01:   pkt_pending <= pkt_pending - ADDR_WIDTH'(1);
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_btle_rx_pdu_buffer.sv
// Bench for btle_rx_pdu_buffer: directed packet table plus random traffic, all
// checked cycle by cycle against a queue-based packet model.
module tb_btle_rx_pdu_buffer;
  localparam int AW       = 6;
  localparam int DEPTH    = 1 << AW;
  localparam int LF_DEPTH = 4;

  logic          clk = 1'b0, rst = 1'b1;
  logic [7:0]    octet = '0;
  logic          octet_valid = 1'b0, decode_end = 1'b0, crc_ok = 1'b0, m_ready = 1'b0;
  logic [7:0]    m_data;
  logic          m_valid, m_last;
  logic [AW-1:0] pkt_pending;
  logic [15:0]   cnt_ok, cnt_crc_err, cnt_ovf;

  btle_rx_pdu_buffer #(.ADDR_WIDTH(AW), .LEN_FIFO_AW(2), .CNT_WIDTH(16)) dut (
    .clk(clk), .rst(rst), .octet(octet), .octet_valid(octet_valid),
    .decode_end(decode_end), .crc_ok(crc_ok), .m_data(m_data), .m_valid(m_valid),
    .m_last(m_last), .m_ready(m_ready), .pkt_pending(pkt_pending),
    .cnt_ok(cnt_ok), .cnt_crc_err(cnt_crc_err), .cnt_ovf(cnt_ovf));

  always #5 clk = ~clk;

  typedef struct { logic [7:0] d; logic l; } exp_t;
  typedef struct {
    int len; logic [7:0] base; bit crc; bit same; bit rdy;
    int ok; int crce; int ovf; int pend;
  } vec_t;

  exp_t       exp_q[$];
  logic [7:0] cur[$];
  int checks = 0, failures = 0;
  int m_ok, m_crc, m_ovf, m_commits, m_reads, m_cbytes, m_consumed, hs_cnt, rdy_mode;
  bit in_pkt, disc, prev_stall;
  logic [7:0] prev_d;
  logic prev_l;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      if (failures <= 40) $display("FAIL %s: got %0h, want %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_clear();
    exp_q.delete(); cur.delete();
    m_ok = 0; m_crc = 0; m_ovf = 0; m_commits = 0; m_reads = 0;
    m_cbytes = 0; m_consumed = 0; hs_cnt = 0;
    in_pkt = 0; disc = 0; prev_stall = 0;
  endtask

  // Called at the falling edge: registered outputs reflect all earlier cycles,
  // inputs are this cycle's.
  task automatic model_cycle();
    int   used, pend;
    exp_t e;
    chk("pkt_pending", 32'(pkt_pending), 32'(m_commits - m_reads));
    chk("cnt_ok", 32'(cnt_ok), 32'(m_ok));
    chk("cnt_crc_err", 32'(cnt_crc_err), 32'(m_crc));
    chk("cnt_ovf", 32'(cnt_ovf), 32'(m_ovf));
    if (prev_stall) begin
      chk("hold_valid", 32'(m_valid), 32'd1);
      chk("hold_data", 32'(m_data), 32'(prev_d));
      chk("hold_last", 32'(m_last), 32'(prev_l));
    end
    used = m_cbytes - m_consumed + cur.size();
    pend = m_commits - m_reads;
    if (octet_valid) begin
      if (!in_pkt) begin in_pkt = 1; disc = 0; cur.delete(); end
      if (!disc) begin
        if (used == DEPTH) disc = 1;
        else begin
          cur.push_back(octet);
          if (cur.size() == 255) disc = 1;
        end
      end
    end
    if (decode_end && in_pkt) begin
      if (disc)                  m_ovf++;
      else if (!crc_ok)          m_crc++;
      else if (pend >= LF_DEPTH) m_ovf++;
      else begin
        foreach (cur[i]) exp_q.push_back('{cur[i], (i == cur.size() - 1)});
        m_ok++; m_commits++; m_cbytes += cur.size();
      end
      in_pkt = 0; cur.delete();
    end
    if (m_valid && m_ready) begin
      hs_cnt++;
      if (exp_q.size() == 0) begin
        checks++; failures++;
        if (failures <= 40) $display("FAIL spurious_byte: got %0h, want no byte at %0t", m_data, $time);
      end else begin
        e = exp_q.pop_front();
        chk("m_data", 32'(m_data), 32'(e.d));
        chk("m_last", 32'(m_last), 32'(e.l));
        m_consumed++;
        if (e.l) m_reads++;
      end
    end
    prev_stall = m_valid && !m_ready;
    prev_d = m_data;
    prev_l = m_last;
  endtask

  task automatic step();
    @(negedge clk);
    model_cycle();
    @(posedge clk); #1;
    case (rdy_mode)
      1: m_ready = ($urandom_range(0, 3) != 0);
      2: m_ready = !m_ready;
      default: ;
    endcase
  endtask

  task automatic send_pkt(input int len, input logic [7:0] base, input bit crc,
                          input bit same, input int gap_max);
    for (int i = 0; i < len; i++) begin
      octet_valid = 1'b1;
      octet = base + 8'(i);
      if (same && i == len - 1) begin decode_end = 1'b1; crc_ok = crc; end
      step();
      octet_valid = 1'b0; decode_end = 1'b0; crc_ok = 1'b0;
      if (gap_max > 0 && i != len - 1) repeat ($urandom_range(0, gap_max)) step();
    end
    if (!same) begin
      decode_end = 1'b1; crc_ok = crc;
      step();
      decode_end = 1'b0; crc_ok = 1'b0;
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_m_valid"}, 32'(m_valid), 32'd0);
    chk({tag, "_m_last"}, 32'(m_last), 32'd0);
    chk({tag, "_m_data"}, 32'(m_data), 32'd0);
    chk({tag, "_pending"}, 32'(pkt_pending), 32'd0);
    chk({tag, "_cnt_ok"}, 32'(cnt_ok), 32'd0);
    chk({tag, "_cnt_crc"}, 32'(cnt_crc_err), 32'd0);
    chk({tag, "_cnt_ovf"}, 32'(cnt_ovf), 32'd0);
  endtask

  task automatic async_reset(input string tag);
    #3 rst = 1'b1;
    octet_valid = 1'b0; decode_end = 1'b0; crc_ok = 1'b0;
    #1 check_reset_outputs(tag);
    model_clear();
    @(posedge clk); #2 rst = 1'b0;
    @(posedge clk); #1;
  endtask

  vec_t tbl[9];
  int   lat, base_ok;

  initial begin
    model_clear();
    rdy_mode = 0;
    repeat (3) @(posedge clk);
    #1 check_reset_outputs("reset");
    #1 rst = 1'b0;
    @(posedge clk); #1;

    // 10-octet good packet: latency, back-to-back streaming, pending 1 -> 0
    m_ready = 1'b1;
    send_pkt(10, 8'h00, 1'b1, 1'b0, 0);
    chk("pending_after_commit", 32'(pkt_pending), 32'd1);
    lat = 1;
    while (!m_valid && lat < 8) begin step(); lat++; end
    chk("first_byte_latency_le3", 32'(lat <= 3), 32'd1);
    for (int k = 0; k < 10; k++) begin
      chk("b2b_valid", 32'(m_valid), 32'd1);
      step();
    end
    chk("pending_after_drain", 32'(pkt_pending), 32'd0);

    tbl[0] = '{10, 8'h00, 1'b0, 1'b0, 1'b1, 1, 1, 0, 0};
    tbl[1] = '{ 4, 8'hA0, 1'b1, 1'b0, 1'b1, 2, 1, 0, 0};
    tbl[2] = '{ 3, 8'h30, 1'b1, 1'b1, 1'b1, 3, 1, 0, 0};
    tbl[3] = '{ 2, 8'h70, 1'b0, 1'b1, 1'b1, 3, 2, 0, 0};
    tbl[4] = '{ 3, 8'h10, 1'b1, 1'b0, 1'b0, 4, 2, 0, 1};
    tbl[5] = '{ 3, 8'h20, 1'b1, 1'b0, 1'b0, 5, 2, 0, 2};
    tbl[6] = '{ 3, 8'h40, 1'b1, 1'b0, 1'b0, 6, 2, 0, 3};
    tbl[7] = '{ 3, 8'h50, 1'b1, 1'b0, 1'b0, 7, 2, 0, 4};
    tbl[8] = '{ 3, 8'h60, 1'b1, 1'b0, 1'b0, 7, 2, 1, 4};
    foreach (tbl[i]) begin
      m_ready = tbl[i].rdy;
      send_pkt(tbl[i].len, tbl[i].base, tbl[i].crc, tbl[i].same, 0);
      repeat (tbl[i].rdy ? 16 : 3) step();
      chk("tbl_cnt_ok", 32'(cnt_ok), 32'(tbl[i].ok));
      chk("tbl_cnt_crc", 32'(cnt_crc_err), 32'(tbl[i].crce));
      chk("tbl_cnt_ovf", 32'(cnt_ovf), 32'(tbl[i].ovf));
      chk("tbl_pending", 32'(pkt_pending), 32'(tbl[i].pend));
    end

    // drain four queued 3-byte packets with m_ready toggling
    hs_cnt = 0; rdy_mode = 2;
    repeat (40) step();
    rdy_mode = 0;
    chk("toggle_drain_bytes", 32'(hs_cnt), 32'd12);
    chk("toggle_drain_pending", 32'(pkt_pending), 32'd0);

    // memory full: 40 + 30 octets into 64 bytes with the reader stalled
    m_ready = 1'b0; hs_cnt = 0;
    send_pkt(40, 8'h80, 1'b1, 1'b0, 0);
    send_pkt(30, 8'hC0, 1'b1, 1'b0, 0);
    repeat (2) step();
    chk("memfull_cnt_ovf", 32'(cnt_ovf), 32'd2);
    chk("memfull_cnt_ok", 32'(cnt_ok), 32'd8);
    m_ready = 1'b1;
    repeat (60) step();
    chk("memfull_out_bytes", 32'(hs_cnt), 32'd40);

    // wrap: 40 packets of 30 octets through a 64-byte memory
    base_ok = m_ok; hs_cnt = 0;
    for (int k = 0; k < 40; k++) send_pkt(30, 8'(k * 7), 1'b1, 1'b0, 1);
    repeat (60) step();
    chk("wrap_commits", 32'(cnt_ok), 32'(base_ok + 40));
    chk("wrap_bytes", 32'(hs_cnt), 32'd1200);

    // reset mid-receive, then a good packet
    for (int i = 0; i < 5; i++) begin
      octet_valid = 1'b1; octet = 8'h90 + 8'(i);
      step();
    end
    octet_valid = 1'b0;
    async_reset("rst_recv");
    send_pkt(6, 8'hE0, 1'b1, 1'b0, 0);
    repeat (15) step();
    chk("post_rst_ok", 32'(cnt_ok), 32'd1);
    chk("post_rst_bytes", 32'(hs_cnt), 32'd6);

    // reset mid-stream, then a good packet
    send_pkt(30, 8'h11, 1'b1, 1'b0, 0);
    repeat (5) step();
    chk("streaming_before_rst", 32'(m_valid), 32'd1);
    async_reset("rst_stream");
    send_pkt(5, 8'h5A, 1'b1, 1'b1, 0);
    repeat (15) step();
    chk("post_rst2_ok", 32'(cnt_ok), 32'd1);
    chk("post_rst2_bytes", 32'(hs_cnt), 32'd5);

    // random traffic with random back-pressure
    rdy_mode = 1;
    for (int k = 0; k < 80; k++) begin
      if ($urandom_range(0, 9) == 0) begin
        decode_end = 1'b1; crc_ok = 1'b1; step();
        decode_end = 1'b0; crc_ok = 1'b0;
      end
      send_pkt($urandom_range(1, 45), 8'($urandom), $urandom_range(0, 4) != 0,
               $urandom_range(0, 4) == 0, 2);
      repeat ($urandom_range(0, 4)) step();
    end
    rdy_mode = 0; m_ready = 1'b1;
    repeat (200) step();
    chk("final_queue_empty", 32'(exp_q.size()), 32'd0);
    chk("final_pending", 32'(pkt_pending), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
